// File: rtl/updown_counter_param.sv
// Two-button up/down counter: each active-low button is synchronised and debounced,
// and each debounced press becomes one count step with wrap or saturate at the limits.
module updown_counter_param #(
   parameter int WIDTH           = 4,
   parameter int MAX_VAL         = (2 ** WIDTH) - 1,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit SATURATE        = 1'b0
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [1:0]       Push,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_Val,
   output logic [WIDTH-1:0] Cnt_o_LED,
   output logic             Limit_o
);

   localparam int              DCW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [WIDTH-1:0] MAX_L     = WIDTH'(MAX_VAL);
   localparam logic [DCW-1:0]   DC_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
   localparam bit               FULL_RANGE = (MAX_VAL == (2 ** WIDTH) - 1);

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be 1..16");
   end
   if (MAX_VAL < 0 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("updown_counter_param: MAX_VAL must fit in WIDTH bits");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $error("updown_counter_param: DEBOUNCE_CYCLES must be >= 1");
   end

   // Bit 1 is the up button, bit 0 the down button; 1 means released.
   logic [1:0]          s1_q, s2_q;
   logic [1:0]          db_q, db_d;
   logic [1:0]          db_prev_q;
   logic [1:0][DCW-1:0] dc_q, dc_d;
   logic [1:0]          press_ev;
   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic                lim_q, lim_d;
   logic [WIDTH-1:0]    load_clamped;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s1_q      <= 2'b11;
         s2_q      <= 2'b11;
         db_q      <= 2'b11;
         db_prev_q <= 2'b11;
         dc_q      <= '0;
      end else begin
         s1_q      <= Push;
         s2_q      <= s1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         dc_q      <= dc_d;
      end
   end

   // A sample that matches the accepted state restarts qualification.
   always_comb begin
      db_d = db_q;
      dc_d = dc_q;
      for (int b = 0; b < 2; b++) begin
         if (s2_q[b] == db_q[b]) begin
            dc_d[b] = '0;
         end else if (dc_q[b] == DC_LAST) begin
            db_d[b] = s2_q[b];
            dc_d[b] = '0;
         end else begin
            dc_d[b] = dc_q[b] + 1'b1;
         end
      end
   end

   assign press_ev = db_prev_q & ~db_q;

   if (FULL_RANGE) begin : g_no_clamp
      assign load_clamped = Load_Val;
   end else begin : g_clamp
      assign load_clamped = (Load_Val > MAX_L) ? MAX_L : Load_Val;
   end

   always_comb begin
      cnt_d = cnt_q;
      lim_d = 1'b0;
      if (Load) begin
         cnt_d = load_clamped;
      end else if (press_ev[1] && press_ev[0]) begin
         cnt_d = cnt_q;
      end else if (press_ev[1]) begin
         if (cnt_q < MAX_L) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            lim_d = 1'b1;
            cnt_d = SATURATE ? cnt_q : '0;
         end
      end else if (press_ev[0]) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            lim_d = 1'b1;
            cnt_d = SATURATE ? cnt_q : MAX_L;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt_q <= '0;
         lim_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end

   assign Cnt_o_LED = cnt_q;
   assign Limit_o   = lim_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: three instances (default wrap, MAX_VAL=9 wrap,
// saturating) exercised with hand-computed press sequences, bounce, load and reset cases.
module tb_updown_counter_param;

   logic       Clk;
   logic       Rst;
   logic [1:0] push0, push1, push2;
   logic       load0, load1, load2;
   logic [3:0] lval0, lval1, lval2;
   logic [3:0] cnt0, cnt1, cnt2;
   logic       lim0, lim1, lim2;

   int errors = 0;
   int checks = 0;
   int lim_total [3] = '{0, 0, 0};

   updown_counter_param u_def (
      .Clk(Clk), .Rst(Rst), .Push(push0), .Load(load0), .Load_Val(lval0),
      .Cnt_o_LED(cnt0), .Limit_o(lim0)
   );

   updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .DEBOUNCE_CYCLES(4), .SATURATE(1'b0)) u_wrap (
      .Clk(Clk), .Rst(Rst), .Push(push1), .Load(load1), .Load_Val(lval1),
      .Cnt_o_LED(cnt1), .Limit_o(lim1)
   );

   updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .DEBOUNCE_CYCLES(4), .SATURATE(1'b1)) u_sat (
      .Clk(Clk), .Rst(Rst), .Push(push2), .Load(load2), .Load_Val(lval2),
      .Cnt_o_LED(cnt2), .Limit_o(lim2)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   // Running count of cycles each Limit_o was seen high.
   always @(posedge Clk) begin
      if (lim0) lim_total[0] = lim_total[0] + 1;
      if (lim1) lim_total[1] = lim_total[1] + 1;
      if (lim2) lim_total[2] = lim_total[2] + 1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, required finish before 3ms");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic set_push(input int idx, input logic [1:0] v);
      case (idx)
         0: push0 = v;
         1: push1 = v;
         default: push2 = v;
      endcase
   endtask

   task automatic set_load(input int idx, input logic l, input logic [3:0] v);
      case (idx)
         0: begin load0 = l; lval0 = v; end
         1: begin load1 = l; lval1 = v; end
         default: begin load2 = l; lval2 = v; end
      endcase
   endtask

   function automatic logic [3:0] get_cnt(input int idx);
      case (idx)
         0: return cnt0;
         1: return cnt1;
         default: return cnt2;
      endcase
   endfunction

   function automatic logic get_lim(input int idx);
      case (idx)
         0: return lim0;
         1: return lim1;
         default: return lim2;
      endcase
   endfunction

   // One 200 ns press followed by a 200 ns release. Observes the count one edge
   // before and on the edge DEBOUNCE_CYCLES+2 after the press edge.
   task automatic do_press(input int idx, input logic [1:0] pv,
                           output logic [3:0] c_before, output logic [3:0] c_after,
                           output logic l_after, output int hits, output logic [3:0] c_final);
      int start_hits;
      @(negedge Clk);
      start_hits = lim_total[idx];
      set_push(idx, pv);
      repeat (6) @(posedge Clk);
      #1 c_before = get_cnt(idx);
      @(posedge Clk);
      #1 c_after = get_cnt(idx);
      l_after = get_lim(idx);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      set_push(idx, 2'b11);
      repeat (10) @(posedge Clk);
      @(negedge Clk);
      hits    = lim_total[idx] - start_hits;
      c_final = get_cnt(idx);
   endtask

   task automatic do_load(input int idx, input logic [3:0] v);
      @(negedge Clk);
      set_load(idx, 1'b1, v);
      @(negedge Clk);
      set_load(idx, 1'b0, 4'd0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Rst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (get_cnt(k) !== 4'd0) begin
            errors++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", k, get_cnt(k));
         end
         checks++;
         if (get_lim(k) !== 1'b0) begin
            errors++; $display("FAIL reset_lim[%0d]: got %b expected 0", k, get_lim(k));
         end
      end
      @(negedge Clk);
      Rst = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (get_cnt(k) !== 4'd0) begin
            errors++; $display("FAIL idle_cnt[%0d]: got %0d expected 0", k, get_cnt(k));
         end
      end
   endtask

   task automatic check_press(input string name, input int idx, input logic [1:0] pv,
                              input logic [3:0] e_before, input logic [3:0] e_after,
                              input logic e_lim);
      logic [3:0] cb, ca, cf;
      logic       la;
      int         h;
      do_press(idx, pv, cb, ca, la, h, cf);
      checks++;
      if (cb !== e_before) begin
         errors++; $display("FAIL %s_early: cnt=%0d expected %0d", name, cb, e_before);
      end
      checks++;
      if (ca !== e_after) begin
         errors++; $display("FAIL %s_step: cnt=%0d expected %0d", name, ca, e_after);
      end
      checks++;
      if (la !== e_lim) begin
         errors++; $display("FAIL %s_limit: Limit_o=%b expected %b", name, la, e_lim);
      end
      checks++;
      if (h !== (e_lim ? 1 : 0)) begin
         errors++; $display("FAIL %s_pulses: %0d limit cycles expected %0d", name, h, e_lim ? 1 : 0);
      end
      checks++;
      if (cf !== e_after) begin
         errors++; $display("FAIL %s_release: cnt=%0d expected %0d", name, cf, e_after);
      end
   endtask

   task automatic test_count_up();
      for (int i = 1; i <= 13; i++)
         check_press($sformatf("up%0d", i), 0, 2'b01, 4'(i - 1), 4'(i), 1'b0);
   endtask

   task automatic test_count_down();
      for (int i = 13; i >= 2; i--)
         check_press($sformatf("down%0d", i), 0, 2'b10, 4'(i), 4'(i - 1), 1'b0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i <= 9; i++)
         check_press($sformatf("wrap_up%0d", i), 1, 2'b01, 4'(i), (i == 9) ? 4'd0 : 4'(i + 1), i == 9);
      check_press("wrap_down0", 1, 2'b10, 4'd0, 4'd9, 1'b1);
   endtask

   task automatic test_saturate();
      for (int p = 1; p <= 20; p++)
         check_press($sformatf("sat_up%0d", p), 2, 2'b01,
                     (p - 1 > 15) ? 4'd15 : 4'(p - 1), (p > 15) ? 4'd15 : 4'(p), p >= 16);
      do_load(2, 4'd0);
      check_press("sat_down0", 2, 2'b10, 4'd0, 4'd0, 1'b1);
   endtask

   task automatic test_bounce();
      int start_hits;
      start_hits = lim_total[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         set_push(0, (i % 2 == 0) ? 2'b01 : 2'b11);
      end
      @(negedge Clk);
      set_push(0, 2'b11);
      repeat (20) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd1) begin
         errors++; $display("FAIL bounce_cnt: cnt=%0d expected 1", cnt0);
      end
      checks++;
      if (lim_total[0] - start_hits !== 0) begin
         errors++; $display("FAIL bounce_limit: %0d limit cycles expected 0", lim_total[0] - start_hits);
      end
   endtask

   task automatic test_simultaneous();
      int start_hits;
      start_hits = lim_total[0];
      @(negedge Clk);
      set_push(0, 2'b00);
      repeat (12) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd1) begin
         errors++; $display("FAIL both_held_cnt: cnt=%0d expected 1", cnt0);
      end
      @(negedge Clk);
      set_push(0, 2'b11);
      repeat (12) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd1) begin
         errors++; $display("FAIL both_release_cnt: cnt=%0d expected 1", cnt0);
      end
      checks++;
      if (lim_total[0] - start_hits !== 0) begin
         errors++; $display("FAIL both_limit: %0d limit cycles expected 0", lim_total[0] - start_hits);
      end
   endtask

   task automatic test_load();
      int start_hits;
      do_load(1, 4'd3);
      #1;
      checks++;
      if (cnt1 !== 4'd3) begin
         errors++; $display("FAIL load3: cnt=%0d expected 3", cnt1);
      end
      do_load(1, 4'd12);
      #1;
      checks++;
      if (cnt1 !== 4'd9) begin
         errors++; $display("FAIL load_clamp: cnt=%0d expected 9", cnt1);
      end
      // Load lands on the same edge as an up event on the default instance (count 1).
      start_hits = lim_total[0];
      @(negedge Clk);
      set_push(0, 2'b01);
      repeat (6) @(posedge Clk);
      @(negedge Clk);
      set_load(0, 1'b1, 4'd9);
      @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd9) begin
         errors++; $display("FAIL load_vs_up: cnt=%0d expected 9", cnt0);
      end
      checks++;
      if (lim0 !== 1'b0) begin
         errors++; $display("FAIL load_vs_up_limit: Limit_o=%b expected 0", lim0);
      end
      @(negedge Clk);
      set_load(0, 1'b0, 4'd0);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      set_push(0, 2'b11);
      repeat (10) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd9) begin
         errors++; $display("FAIL load_vs_up_after: cnt=%0d expected 9", cnt0);
      end
      checks++;
      if (lim_total[0] - start_hits !== 0) begin
         errors++; $display("FAIL load_vs_up_pulses: %0d limit cycles expected 0", lim_total[0] - start_hits);
      end
   endtask

   task automatic test_reset_mid_press();
      @(negedge Clk);
      set_push(0, 2'b01);
      repeat (3) @(posedge Clk);
      #5 Rst = 1'b0;
      #1;
      checks++;
      if (cnt0 !== 4'd0) begin
         errors++; $display("FAIL async_reset_def: cnt=%0d expected 0", cnt0);
      end
      checks++;
      if (cnt1 !== 4'd0) begin
         errors++; $display("FAIL async_reset_wrap: cnt=%0d expected 0", cnt1);
      end
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (6) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd0) begin
         errors++; $display("FAIL held_early: cnt=%0d expected 0", cnt0);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd1) begin
         errors++; $display("FAIL held_step: cnt=%0d expected 1", cnt0);
      end
      repeat (10) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd1) begin
         errors++; $display("FAIL held_no_repeat: cnt=%0d expected 1", cnt0);
      end
      @(negedge Clk);
      set_push(0, 2'b11);
      repeat (10) @(posedge Clk);
      #1;
      checks++;
      if (cnt0 !== 4'd1) begin
         errors++; $display("FAIL held_release: cnt=%0d expected 1", cnt0);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      Rst   = 1'b0;
      push0 = 2'b11; push1 = 2'b11; push2 = 2'b11;
      load0 = 1'b0;  load1 = 1'b0;  load2 = 1'b0;
      lval0 = 4'd0;  lval1 = 4'd0;  lval2 = 4'd0;
      test_reset();
      test_count_up();
      test_count_down();
      test_wrap();
      test_saturate();
      test_bounce();
      test_simultaneous();
      test_load();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the board push-button up/down counter. It takes two active-low push buttons, synchronises and debounces each one, and turns each debounced press into a single count step. Width, upper limit and debounce length are configurable. Overflow can either wrap or saturate, a synchronous load path presets the value, and a one-cycle limit flag marks boundary events. The output drives the LED bank.

Parameters:
WIDTH, 4, counter width in bits (1..16)
MAX_VAL, 2**WIDTH-1, highest count value; legal range 0..MAX_VAL
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a button state change (>=1)
SATURATE, 0, 0 = wrap at limits, 1 = clamp at limits

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous active-low reset
Push  input  2  raw buttons, active-low; Push[1] = up, Push[0] = down; 2'b11 = idle
Load  input  1  synchronous load strobe, active-high
Load_Val  input  WIDTH  value to load
Cnt_o_LED  output  WIDTH  current count
Limit_o  output  1  one-cycle pulse when a step crosses or hits a boundary

Behaviour:
- Reset (Rst=0, asynchronous):
  - Cnt_o_LED=0, Limit_o=0.
  - Synchronisers and debounced state = released (1).
  - Debounce counters = 0.
- Per button (identical, independent):
  - 2-flop synchroniser s1, s2.
  - Debounced state db and counter dc.
  - If s2==db: dc<=0.
  - Else if dc==DEBOUNCE_CYCLES-1: db<=s2, dc<=0.
  - Else: dc<=dc+1.
  - Any bounce back to db restarts the qualification.
- Press event: db_prev registered copy of db; event = db_prev & ~db (1->0 transition), one cycle wide. Release produces no event.
- Latency: Push level stable from sampling edge N -> db changes at edge N+1+DEBOUNCE_CYCLES -> Cnt_o_LED updates at edge N+2+DEBOUNCE_CYCLES.
- Holding a button produces exactly one step; no auto-repeat.
- Count update priority (per edge):
  1. Load=1: Cnt<=min(Load_Val, MAX_VAL). Pending events that cycle are discarded. Limit_o=0.
  2. Up and down events in the same cycle: no change, Limit_o=0.
  3. Up event:
     - Cnt<MAX_VAL: Cnt+1.
     - Cnt==MAX_VAL: SATURATE=0 -> Cnt<=0; SATURATE=1 -> hold. Either way Limit_o=1 next cycle.
  4. Down event:
     - Cnt>0: Cnt-1.
     - Cnt==0: SATURATE=0 -> Cnt<=MAX_VAL; SATURATE=1 -> hold. Either way Limit_o=1.
  5. Otherwise hold, Limit_o=0.
- Limit_o is registered and asserted for exactly one cycle per boundary event.
- Arithmetic is WIDTH bits. MAX_VAL < 2**WIDTH is enforced by an elaboration check.
- Reset mid-debounce or mid-press: all state clears immediately.
  - A button still held low after reset release must qualify afresh.
  - It then produces one event DEBOUNCE_CYCLES+2 edges after reset deassertion.
- The count never leaves 0..MAX_VAL.

Test Plan:
- Defaults, 20 ns clock: reset, then 13 presses of Push=2'b01 for 200 ns separated by 2'b11 for 200 ns -> Cnt_o_LED steps 1..13; each step lands DEBOUNCE_CYCLES+2 edges after the press edge.
- Continue with 12 presses of Push=2'b10 -> count steps 13 down to 1, no Limit_o pulses.
- Wrap, SATURATE=0, MAX_VAL=9:
  - 10 up presses from 0 -> sequence 1..9,0; Limit_o pulses once on the 9->0 step.
  - One down press at 0 -> 9, Limit_o pulse.
- Saturate, SATURATE=1: 20 up presses -> stays at 15; Limit_o pulses on presses 16..20 only; down at 0 holds 0 with a pulse.
- Bounce and simultaneous press:
  - Toggle Push[1] every cycle for 10 cycles, then release -> no count change.
  - Both buttons asserted on the same edge and held -> no change, Limit_o=0.
- Load and reset:
  - Load=1 with Load_Val=12 while MAX_VAL=9 -> Cnt_o_LED=9.
  - Load coinciding with an up event -> 9, not 10.
  - Rst low mid-debounce -> Cnt_o_LED=0 asynchronously.
  - Button held through reset release -> exactly one step after DEBOUNCE_CYCLES+2 edges.
